stopwatch_core: RTL and testbench
=================================

STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter MAX_MIN, default 59, meaning the highest minute value before the count wraps to zero (range 1..99).
REQ-002 clk  input  1  system clock, 50 MHz.
REQ-003 rst  input  1  reset, synchronous and active-high; it is sampled only on the rising edge of clk.
REQ-004 tick_10hz  input  1  one-cycle pulse, at most one per 10 clk cycles, from the divider; it is the count time base.
REQ-005 btn_start_stop  input  1  one-cycle pulse, already debounced; toggles run/pause.
REQ-006 btn_lap  input  1  one-cycle pulse, already debounced; toggles the lap freeze.
REQ-007 btn_clear  input  1  one-cycle pulse, already debounced; zeroes the count when the block is stopped.
REQ-008 running  output  1  high in the RUN and RUN_LAP states.
REQ-009 lap_active  output  1  high in the RUN_LAP state.
REQ-010 disp_min_t, disp_min_o, disp_sec_t, disp_sec_o, disp_tenth  output  4 each  BCD display digits (MM:SS.T).
REQ-011 rollover  output  1  one-cycle pulse when the count wraps from MAX_MIN:59.9 to 00:00.0.

Function
REQ-012 The block SHALL implement four states with these transitions:
- IDLE: start_stop goes to RUN.
- RUN: start_stop goes to PAUSED; lap goes to RUN_LAP.
- RUN_LAP: lap goes to RUN; start_stop goes to PAUSED.
- PAUSED: start_stop goes to RUN; clear goes to IDLE.
REQ-013 When buttons pulse in the same cycle, priority SHALL be clear > start_stop > lap; the lower-priority pulses in that cycle SHALL be discarded.
REQ-014 btn_clear SHALL be ignored in RUN and RUN_LAP; btn_lap SHALL be ignored in IDLE and PAUSED.
REQ-015 The internal count SHALL increment by 0.1 s on tick_10hz when the current registered state is RUN or RUN_LAP; the state in effect is the one before any transition taken in the same cycle.
REQ-016 Digit ranges and carries:
- tenth counts 0..9 and carries into sec_o.
- sec_o counts 0..9 and carries into sec_t.
- sec_t counts 0..5 and carries into the minutes.
- Minutes count 00..MAX_MIN in BCD.
REQ-017 On a tick at MAX_MIN:59.9 the count SHALL become 00:00.0, rollover SHALL pulse high in the following cycle, and the state SHALL remain unchanged.
REQ-018 Display outputs SHALL be registered, and SHALL reflect a count change exactly one cycle after the tick edge (latency 1).
REQ-019 On entry to RUN_LAP, the display SHALL hold the count value present in that cycle; counting SHALL continue internally.
REQ-020 On leaving RUN_LAP, to either RUN or PAUSED, the display SHALL show the live count from the next cycle onward.
REQ-021 Clearing from PAUSED SHALL zero the count and the display in the same cycle the state register takes IDLE.
REQ-022 A tick that coincides with a transition out of IDLE or PAUSED SHALL NOT count.

Reset
REQ-023 In a reset cycle the block SHALL:
- force state IDLE;
- set all count digits and display digits to 0;
- set running, lap_active and rollover to 0.
REQ-024 Reset SHALL take priority over all button and tick inputs in the same cycle, including a reset asserted mid-run or mid-lap.
REQ-025 Outputs SHALL hold their reset values until the first cycle after rst deasserts.

Structure
REQ-026 A shared package stopwatch_pkg SHALL hold:
- the state enumeration (IDLE, RUN, PAUSED, RUN_LAP);
- the 4-bit BCD digit type;
- the constants TENTH_MAX=9, SEC_O_MAX=9, SEC_T_MAX=5.
REQ-027 A sub-module bcd_digit_counter SHALL provide one mod-N BCD digit with inputs inc and clr, and outputs value and carry; it SHALL be instantiated once per digit and chained by carry.

Verification
REQ-028 Reset, then start_stop, then 25 ticks -> display 00:02.5, running=1.
REQ-029 From 00:02.5:
- lap, then 12 ticks -> display stays 00:02.5 and lap_active=1;
- then lap -> display shows 00:03.7.
REQ-030 Count preset to 00:59.9, then 1 tick -> 01:00.0; with MAX_MIN=1, a count at 01:59.9 and 1 tick -> 00:00.0, with rollover high for exactly 1 cycle.
REQ-031 Clear issued in RUN -> ignored, count unchanged; then start_stop (to PAUSED), then clear -> IDLE with display 00:00.0.
REQ-032 In RUN, start_stop and tick in the same cycle -> the tick counts and the state becomes PAUSED; in PAUSED, start_stop and tick in the same cycle -> the tick does not count.
REQ-033 rst asserted in RUN_LAP at 00:07.3 -> the next cycle shows IDLE, 00:00.0, and all flags 0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state, digit types and digit limits for the stopwatch core.
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, RUN_LAP} state_e;
  typedef logic [3:0] bcd_t;
  typedef struct packed {bcd_t min_t, min_o, sec_t, sec_o, tenth;} digits_t;
  localparam bcd_t TENTH_MAX = 4'd9;
  localparam bcd_t SEC_O_MAX = 4'd9;
  localparam bcd_t SEC_T_MAX = 4'd5;
endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: one mod-(MAX+1) BCD digit; carry is combinational so digits chain in one cycle.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = 4'd9
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output bcd_t value_o,
  output bcd_t next_o,
  output logic carry_o
);
  bcd_t value_q, value_d;
  always_comb value_d = clr_i ? '0 : inc_i ? (value_q == MAX ? '0 : value_q + 4'd1) : value_q;
  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else value_q <= value_d;
  end
  assign carry_o = inc_i && value_q == MAX;
  assign value_o = value_q;
  assign next_o  = value_d;
endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS.T stopwatch with run/pause, lap freeze, clear and rollover pulse.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = 59
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_10hz,
  input  logic btn_start_stop,
  input  logic btn_lap,
  input  logic btn_clear,
  output logic running,
  output logic lap_active,
  output bcd_t disp_min_t,
  output bcd_t disp_min_o,
  output bcd_t disp_sec_t,
  output bcd_t disp_sec_o,
  output bcd_t disp_tenth,
  output logic rollover
);
  localparam bcd_t MIN_T = bcd_t'(MAX_MIN / 10);
  localparam bcd_t MIN_O = bcd_t'(MAX_MIN % 10);
  state_e state_q, state_d;
  digits_t disp_q;
  logic running_q, lap_q, rollover_q;
  bcd_t [4:0] cur, nxt;
  logic [4:0] cy, inc;
  logic active, cnt_en, clear_ok, wrap, clr;
  assign active   = state_q == RUN || state_q == RUN_LAP;
  assign cnt_en   = tick_10hz && active;
  assign clear_ok = btn_clear && !active;
  assign inc      = {cy[3:0], cnt_en};
  // cy[4] can only fire at 99:59.9, which is itself the wrap point
  assign wrap     = (cy[2] && cur[4] == MIN_T && cur[3] == MIN_O) || cy[4];
  assign clr      = clear_ok || wrap;
  for (genvar i = 0; i < 5; i++) begin : g_dig
    bcd_digit_counter #(
      .MAX(i == 2 ? SEC_T_MAX : i == 1 ? SEC_O_MAX : TENTH_MAX)
    ) u_dig (
      .clk(clk), .rst(rst), .inc_i(inc[i]), .clr_i(clr),
      .value_o(cur[i]), .next_o(nxt[i]), .carry_o(cy[i])
    );
  end
  always_comb
    state_d = clear_ok ? IDLE :
              btn_start_stop ? (active ? PAUSED : RUN) :
              (btn_lap && active) ? (state_q == RUN ? RUN_LAP : RUN) : state_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      running_q  <= 1'b0;
      lap_q      <= 1'b0;
      rollover_q <= 1'b0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      running_q  <= state_d == RUN || state_d == RUN_LAP;
      lap_q      <= state_d == RUN_LAP;
      rollover_q <= wrap;
      disp_q     <= state_d == RUN_LAP ? disp_q : digits_t'(nxt);
    end
  end
  assign running    = running_q;
  assign lap_active = lap_q;
  assign rollover   = rollover_q;
  assign disp_min_t = disp_q.min_t;
  assign disp_min_o = disp_q.min_o;
  assign disp_sec_t = disp_q.sec_t;
  assign disp_sec_o = disp_q.sec_o;
  assign disp_tenth = disp_q.tenth;
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed scoreboard bench for stopwatch_core (MAX_MIN=1 to reach the wrap quickly).
module tb_stopwatch_core;
  import stopwatch_pkg::*;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, ss = 1'b0, lp = 1'b0, cl = 1'b0;
  logic running, lap_active, rollover;
  bcd_t mt, mo, st, so, te;
  typedef struct {string tag; logic [22:0] v;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;

  stopwatch_core #(.MAX_MIN(1)) dut (
    .clk(clk), .rst(rst), .tick_10hz(tick), .btn_start_stop(ss), .btn_lap(lp), .btn_clear(cl),
    .running(running), .lap_active(lap_active),
    .disp_min_t(mt), .disp_min_o(mo), .disp_sec_t(st), .disp_sec_o(so), .disp_tenth(te),
    .rollover(rollover)
  );

  always #10 clk = ~clk;

  task automatic drive(input logic r, s, l, c, t);
    @(negedge clk);
    rst = r; ss = s; lp = l; cl = c; tick = t;
    @(posedge clk);
    #1;
    rst = 0; ss = 0; lp = 0; cl = 0; tick = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      drive(0, 0, 0, 0, 1);
      repeat (9) @(posedge clk);
    end
  endtask

  task automatic chk(input string tag, input logic [19:0] d, input logic r, l, ro);
    exp_t e;
    logic [22:0] obs;
    sb.push_back('{tag, {d, r, l, ro}});
    @(negedge clk);
    e = sb.pop_front();
    obs = {mt, mo, st, so, te, running, lap_active, rollover};
    total++;
    assert (obs === e.v) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.v);
    end
  endtask

  initial begin
    tick = 1; ss = 1;
    repeat (3) @(posedge clk);
    chk("rst_hold", 20'h00000, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("rst_release", 20'h00000, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    chk("start", 20'h00000, 1, 0, 0);
    ticks(25);
    chk("run_25", 20'h00025, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    chk("lap_enter", 20'h00025, 1, 1, 0);
    ticks(12);
    chk("lap_hold", 20'h00025, 1, 1, 0);
    drive(0, 0, 1, 0, 0);
    chk("lap_exit", 20'h00037, 1, 0, 0);
    drive(0, 1, 0, 0, 1);
    chk("ss_tick_run", 20'h00038, 0, 0, 0);
    drive(0, 1, 0, 0, 1);
    chk("ss_tick_paused", 20'h00038, 1, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("clear_in_run", 20'h00038, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    chk("tick_latency", 20'h00039, 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    chk("pause", 20'h00039, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    chk("lap_in_paused", 20'h00039, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("clear_paused", 20'h00000, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    chk("restart", 20'h00000, 1, 0, 0);
    ticks(4);
    drive(0, 1, 0, 0, 0);
    chk("pause2", 20'h00004, 0, 0, 0);
    drive(0, 1, 0, 1, 0);
    chk("clear_beats_ss", 20'h00000, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    chk("tick_idle", 20'h00000, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    ticks(599);
    chk("run_59_9", 20'h00599, 1, 0, 0);
    ticks(1);
    chk("min_carry", 20'h01000, 1, 0, 0);
    ticks(599);
    chk("run_1_59_9", 20'h01599, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    chk("wrap", 20'h00000, 1, 0, 1);
    chk("wrap_pulse_end", 20'h00000, 1, 0, 0);
    ticks(73);
    chk("run_7_3", 20'h00073, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    ticks(3);
    chk("lap_7_3", 20'h00073, 1, 1, 0);
    drive(1, 1, 1, 0, 1);
    chk("rst_in_lap", 20'h00000, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    chk("count_zeroed", 20'h00001, 1, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
